// File: rtl/rsa_decryption.sv
// Modular exponentiation engine: M = C^d mod n, by right-to-left square-and-multiply.
// The engine handles one exponent bit per clock. The FSM returns to IDLE one cycle after done.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the start edge
// RUN   | one exponent bit consumed per edge until exp reaches zero
// DONE  | done pulse cycle; the next edge returns to IDLE
module rsa_decryption #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] C,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] M,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] base_q, base_d;
    logic [W-1:0] exp_q, exp_d;
    logic [W-1:0] mod_q, mod_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] m_q, m_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Full double-width products, so that no bits are lost before the reduction.
    logic [2*W-1:0] prod_rb, prod_bb;
    logic [W-1:0]   red_rb, red_bb;

    // Form the products and reduce them modulo the captured modulus.
    always_comb begin
        prod_rb = {{W{1'b0}}, result_q} * {{W{1'b0}}, base_q};
        prod_bb = {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
        red_rb  = W'(prod_rb % {{W{1'b0}}, mod_q});
        red_bb  = W'(prod_bb % {{W{1'b0}}, mod_q});
    end

    // Compute the next-state values and the next registered outputs.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        result_d = result_q;
        m_d      = m_q;
        err_d    = err_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n < W'(2)) begin
                        m_d     = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        base_d   = C % n;
                        exp_d    = d;
                        mod_d    = n;
                        result_d = W'(1);
                        err_d    = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (exp_q != '0) begin
                    if (exp_q[0]) begin
                        result_d = red_rb;
                    end
                    base_d = red_bb;
                    exp_d  = exp_q >> 1;
                    busy_d = 1'b1;
                end else begin
                    m_d     = result_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register the state, the datapath and the outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            result_q <= '0;
            m_q      <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            result_q <= result_d;
            m_q      <= m_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign M    = m_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Testbench for rsa_decryption: directed and random requests checked against an arithmetic reference model.
module tb_rsa_decryption;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] C, d, n;
    logic         busy, done, err;
    logic [W-1:0] M;

    int total = 0;
    int bad   = 0;

    rsa_decryption #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .C(C), .d(d), .n(n),
        .busy(busy), .done(done), .M(M), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: left-to-right (MSB-first) exponentiation with wide arithmetic.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] c_i, input logic [W-1:0] e_i,
                                                 input logic [W-1:0] m_i);
        logic [2*W-1:0] b, r, m;
        if (m_i < 2) return '0;
        m = {{W{1'b0}}, m_i};
        b = {{W{1'b0}}, c_i} % m;
        r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e_i[i]) r = (r * b) % m;
        end
        return r[W-1:0];
    endfunction

    function automatic int bit_len(input logic [W-1:0] v);
        int k = 0;
        for (int i = 0; i < W; i++) if (v[i]) k = i + 1;
        return k;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input logic [W-1:0] c_i, input logic [W-1:0] d_i, input logic [W-1:0] n_i,
                          input bit disturb, input string tag);
        logic [W-1:0] exp_m;
        logic         exp_err;
        int           exp_lat, exp_busy, e, busy_cnt;
        exp_m    = ref_modexp(c_i, d_i, n_i);
        exp_err  = (n_i < 2);
        exp_lat  = exp_err ? 0 : bit_len(d_i) + 1;
        exp_busy = exp_err ? 0 : bit_len(d_i) + 1;

        @(negedge clk);
        C = c_i; d = d_i; n = n_i; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && e < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (disturb && e == 1) begin
                start = 1'b1;
                C = {$urandom, $urandom};
                d = {$urandom, $urandom};
                n = {$urandom, $urandom};
            end
            if (disturb && e == 2) start = 1'b0;
            @(posedge clk);
            #1;
            e++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, W'(done), W'(1));
        check({tag, " latency"}, W'(e), W'(exp_lat));
        check({tag, " M"}, M, exp_m);
        check({tag, " err"}, W'(err), W'(exp_err));
        check({tag, " busy_cycles"}, W'(busy_cnt), W'(exp_busy));
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, W'(done), W'(0));
        check({tag, " M_held"}, M, exp_m);
        check({tag, " err_held"}, W'(err), W'(exp_err));
    endtask

    initial begin
        int dn;
        logic [W-1:0] rc, rd, rn;
        rst = 1'b1; start = 1'b0; C = '0; d = '0; n = '0;
        #12;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset err", W'(err), W'(0));
        check("reset M", M, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(29, 7, 33, 1'b0, "c29_d7_n33");
        run_op(2790, 2753, 3233, 1'b0, "c2790_d2753");
        run_op(6023, 2753, 3233, 1'b0, "c_ge_n");
        run_op(5, 0, 33, 1'b0, "d_zero");
        run_op(77, 12345, 1, 1'b0, "n_one");
        run_op(77, 3, 0, 1'b0, "n_zero");
        run_op(29, 7, 33, 1'b0, "after_err");

        // Reset three edges into a long run.
        @(negedge clk);
        C = 2790; d = 2753; n = 3233; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst busy", W'(busy), W'(0));
        check("midrun_rst M", M, '0);
        check("midrun_rst done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        check("midrun_rst no_done", W'(dn), W'(0));
        run_op(29, 7, 33, 1'b0, "post_rst");

        run_op(2790, 2753, 3233, 1'b1, "disturbed");

        for (int i = 0; i < 8; i++) begin
            rc = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            rn = {$urandom, $urandom};
            run_op(rc, rd, rn, 1'b0, "rand_wide");
        end
        for (int i = 0; i < 6; i++) begin
            rc = W'($urandom_range(0, 5000));
            rd = W'($urandom_range(0, 4000));
            rn = W'($urandom_range(0, 1000));
            run_op(rc, rd, rn, (i % 2) == 1, "rand_small");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rsa_decryption.md
RSA_DECRYPTION -- requirements
Module: rsa_decryption

Interface
REQ-001 Parameter: W, 64, operand width in bits for C, d, n and M.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: C  input  W  cipher text, unsigned.
REQ-006 Port: d  input  W  private exponent, unsigned.
REQ-007 Port: n  input  W  modulus, unsigned.
REQ-008 Port: busy  output  1  high while state is RUN.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: M  output  W  recovered plain text, M = C^d mod n.
REQ-011 Port: err  output  1  high when the last request had n < 2.

Function
REQ-012 The block SHALL use the FSM states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 and n>=2 at an edge SHALL perform these loads: base = C mod n, exp = d, modulus = n, result = 1, err = 0; state becomes RUN.
REQ-014 IDLE with start=1 and n<2 at an edge SHALL set M=0 and err=1 and move to DONE; it SHALL NOT enter RUN.
REQ-015 C, d and n SHALL be sampled only at the start edge; input changes afterward SHALL have no effect on the result.
REQ-016 Each RUN edge with exp!=0 SHALL perform these updates: if exp[0] then result = (result*base) mod modulus; base = (base*base) mod modulus; exp = exp>>1.
REQ-017 Products SHALL be formed at 2W bits before reduction; no truncation is permitted before the mod.
REQ-018 A RUN edge with exp==0 SHALL load M = result and move to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next edge returns to IDLE.
REQ-020 Latency: with k = index of the most significant set bit of d plus 1 (k=0 for d=0), done SHALL be high in the cycle after edge t+k+1, where t is the start edge; for n<2, done SHALL be high in the cycle after edge t.
REQ-021 start SHALL be ignored in RUN and DONE; it SHALL NOT be queued.
REQ-022 M and err SHALL hold their values from done until the next accepted start.
REQ-023 d=0 with n>=2 SHALL yield M=1.
REQ-024 C>=n SHALL be reduced at load and yield the same M as C mod n.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE and busy=0, done=0, err=0, M=0, independent of clk.
REQ-026 rst asserted during RUN SHALL abort the operation with no done pulse.
REQ-027 The first start after rst deasserts SHALL be processed normally.

Verification
REQ-028 C=29, d=7, n=33, start pulse -> done high 4 edges after start edge, M=17, err=0, busy high for 4 cycles.
REQ-029 C=2790, d=2753, n=3233 -> done 13 edges after start, M=65.
REQ-030 C=6023, d=2753, n=3233 (C>=n) -> M=65; C=5, d=0, n=33 -> done 1 edge after start, M=1.
REQ-031 n=1, any C and d -> done in the cycle after the start edge, err=1, M=0, busy never high.
REQ-032 rst pulse 3 cycles into the d=2753 run -> busy=0, M=0, no done; then a start with C=29, d=7, n=33 -> M=17.
REQ-033 A second start pulse and changes to C, d and n during RUN -> ignored; result matches the original request.
